// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD-to-binary converter.
//   state_t       : converter FSM states (IDLE, CHECK, SHIFT, DONE)
//   BCD_MAX_DIGIT : largest legal BCD nibble value
//   ADJ_THRESH    : nibble value at or above which the reverse double-dabble
//                   correction applies
//   ADJ_VAL       : correction subtracted from such a nibble
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_VAL       = 4'd3;

endpackage

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: request/response bundle of the BCD-to-binary converter.
//   start     : request pulse from the master; sampled only while idle
//   In_BCD    : packed BCD operand, digit 0 in bits [3:0]
//   busy      : converter is not idle
//   done      : one-cycle completion pulse
//   err       : operand held a nibble > 9 (valid from done on)
//   Out_Bin   : binary result (valid from done on)
//   dbg_state : current FSM state, for observation only
//
// Handshake: the master raises start with In_BCD stable; the request is
// accepted at the first rising edge where start=1 and busy=0, and In_BCD is
// captured at that edge. While busy=1 (including the done cycle) start is
// ignored and never queued. done pulses for exactly one cycle; Out_Bin and err
// are valid in that cycle and hold until the next done.
interface bcd_to_bin_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   In_BCD;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [OUT_W-1:0]      Out_Bin;
    state_t                dbg_state;

    modport master (
        output start, In_BCD,
        input  busy, done, err, Out_Bin, dbg_state
    );

    modport slave (
        input  start, In_BCD,
        output busy, done, err, Out_Bin, dbg_state
    );
endinterface

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: combinational per-digit helper.
//   nib_i     : one BCD nibble
//   nib_o     : nib_i - 3 when nib_i >= 8, otherwise nib_i (no borrow out)
//   invalid_o : nib_i is not a legal BCD digit (> 9)
module bcd_nibble_adj
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o,
    output logic       invalid_o
);

    assign nib_o     = (nib_i >= ADJ_THRESH) ? (nib_i - ADJ_VAL) : nib_i;
    assign invalid_o = (nib_i > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double-dabble,
// one binary bit per clock).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : bcd_to_bin_if slave (start/In_BCD in; busy/done/err/Out_Bin out)
// Latency from the accepted start edge: done in cycle OUT_W+2 for a valid
// operand, cycle 2 for an operand with an illegal nibble.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 8
)(
    input  logic         clk,
    input  logic         reset,
    bcd_to_bin_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
    localparam longint MAX_VAL = (10 ** DIGITS) - 1;

    // The result register must hold the largest DIGITS-digit decimal value.
    if (OUT_W < 62 && (longint'(1) << OUT_W) <= MAX_VAL) begin : g_width_check
        $error("bcd_to_bin: OUT_W too small for DIGITS");
    end

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [OUT_W-1:0]   bin_q,   bin_d;
    logic [OUT_W-1:0]   out_q,   out_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [BCD_W-1:0]   bcd_shift;
    logic [OUT_W-1:0]   bin_shift;
    logic [BCD_W-1:0]   adj_in;
    logic [BCD_W-1:0]   adj_out;
    logic [DIGITS-1:0]  nib_bad;

    // {bcd, bin} shifted right by one: bcd LSB moves into bin MSB.
    assign bcd_shift = bcd_q >> 1;
    assign bin_shift = {bcd_q[0], bin_q[OUT_W-1:1]};

    // The nibble helpers validate the captured operand in CHECK and correct
    // the freshly shifted digits in SHIFT; one set of instances serves both.
    assign adj_in = (state_q == CHECK) ? bcd_q : bcd_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        bcd_nibble_adj u_adj (
            .nib_i     (adj_in[4*g +: 4]),
            .nib_o     (adj_out[4*g +: 4]),
            .invalid_o (nib_bad[g])
        );
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        out_d   = out_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d   = bus.In_BCD;
                    bin_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (|nib_bad) begin
                    // Result registers are loaded on the edge into DONE so
                    // they are already valid while done is high.
                    out_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = adj_out;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    out_d   = bin_shift;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            out_q   <= out_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.Out_Bin   = out_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed bench for bcd_to_bin (DIGITS=2, OUT_W=8).
module tb_bcd_to_bin;
    import bcd_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;

    bcd_to_bin_if #(.DIGITS(2), .OUT_W(8)) bus ();

    bcd_to_bin #(.DIGITS(2), .OUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. Raises start for one edge, then
    // watches up to 40 cycles. Returns at the negedge of the first idle cycle
    // after done, so the next call starts at minimum spacing.
    task automatic do_conv(input logic [7:0] bcd, output int lat,
                           output logic [7:0] out, output logic e,
                           output int n_done);
        lat    = -1;
        out    = 8'h00;
        e      = 1'b0;
        n_done = 0;
        bus.start  = 1'b1;
        bus.In_BCD = bcd;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (lat < 0) begin
                    lat = cyc;
                    out = bus.Out_Bin;
                    e   = bus.err;
                end
            end else if (lat >= 0 && !bus.busy) begin
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.start  = 1'b0;
        bus.In_BCD = 8'h00;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.Out_Bin !== 8'h00 || bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b err=%b out=%h state=%0d, need 0 0 0 00 IDLE",
                     bus.busy, bus.done, bus.err, bus.Out_Bin, bus.dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max();
        logic bh [0:12];
        logic dh [0:12];
        logic [7:0] out;
        logic e;
        out = 8'h00;
        e   = 1'b1;
        bus.start  = 1'b1;
        bus.In_BCD = 8'h99;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            bh[cyc] = bus.busy;
            dh[cyc] = bus.done;
            if (bus.done) begin
                out = bus.Out_Bin;
                e   = bus.err;
            end
        end
        n_vec++;
        if (bh[1] !== 1'b1) begin
            n_fail++; $display("FAIL max_busy_c1: busy=%b need 1", bh[1]);
        end
        n_vec++;
        if (dh[9] !== 1'b0 || dh[10] !== 1'b1 || dh[11] !== 1'b0) begin
            n_fail++; $display("FAIL max_done_c10: done c9/c10/c11=%b%b%b need 010", dh[9], dh[10], dh[11]);
        end
        n_vec++;
        if (out !== 8'h63) begin
            n_fail++; $display("FAIL max_out: got %h need 63", out);
        end
        n_vec++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL max_err: got %b need 0", e);
        end
        n_vec++;
        if (bh[11] !== 1'b0) begin
            n_fail++; $display("FAIL max_busy_c11: busy=%b need 0", bh[11]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nd;
        logic [7:0] out;
        logic e;
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                logic [7:0] bcd;
                logic [7:0] exp_bin;
                bcd     = {4'(t), 4'(u)};
                exp_bin = 8'(t * 10 + u);
                do_conv(bcd, lat, out, e, nd);
                n_vec++;
                if (out !== exp_bin || e !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_value %h: out=%h err=%b, need %h 0", bcd, out, e, exp_bin);
                end
                n_vec++;
                if (lat != 10 || nd != 1) begin
                    n_fail++;
                    $display("FAIL b2b_timing %h: done cycle %0d count %0d, need 10 1", bcd, lat, nd);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int lat, nd;
        logic [7:0] out;
        logic e;
        logic [7:0] bad [2];
        bad[0] = 8'h4A;
        bad[1] = 8'hA3;
        for (int i = 0; i < 2; i++) begin
            do_conv(bad[i], lat, out, e, nd);
            n_vec++;
            if (lat != 2 || nd != 1) begin
                n_fail++;
                $display("FAIL invalid_timing %h: done cycle %0d count %0d, need 2 1", bad[i], lat, nd);
            end
            n_vec++;
            if (e !== 1'b1 || out !== 8'h00) begin
                n_fail++;
                $display("FAIL invalid_result %h: err=%b out=%h, need 1 00", bad[i], e, out);
            end
        end
        do_conv(8'h12, lat, out, e, nd);
        n_vec++;
        if (e !== 1'b0 || out !== 8'd12 || lat != 10) begin
            n_fail++;
            $display("FAIL invalid_recover: err=%b out=%h cycle %0d, need 0 0c 10", e, out, lat);
        end
    endtask

    task automatic test_ignored_start();
        int nd;
        int idle_bad;
        logic [7:0] out;
        nd       = 0;
        idle_bad = 0;
        out      = 8'h00;
        bus.start  = 1'b1;
        bus.In_BCD = 8'h37;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                out = bus.Out_Bin;
            end
            if (cyc >= 11 && bus.busy !== 1'b0) idle_bad++;
            // Requests held across a SHIFT edge and across the DONE edge.
            if (cyc == 4 || cyc == 10) begin
                bus.start  = 1'b1;
                bus.In_BCD = 8'h88;
            end else begin
                bus.start  = 1'b0;
            end
        end
        n_vec++;
        if (nd != 1) begin
            n_fail++; $display("FAIL ignored_done_count: got %0d need 1", nd);
        end
        n_vec++;
        if (out !== 8'h25) begin
            n_fail++; $display("FAIL ignored_out: got %h need 25", out);
        end
        n_vec++;
        if (idle_bad != 0) begin
            n_fail++; $display("FAIL ignored_not_queued: busy seen %0d cycles after done, need 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        logic [7:0] out;
        logic e;
        nd = 0;
        bus.start  = 1'b1;
        bus.In_BCD = 8'h64;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.Out_Bin !== 8'h00 || bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b out=%h state=%0d, need 0 0 0 00 IDLE",
                     bus.busy, bus.done, bus.err, bus.Out_Bin, bus.dbg_state);
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        n_vec++;
        if (nd != 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: %0d done pulses, need 0", nd);
        end
        do_conv(8'h64, lat, out, e, nd);
        n_vec++;
        if (out !== 8'h40 || e !== 1'b0 || lat != 10) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: out=%h err=%b cycle %0d, need 40 0 10", out, e, lat);
        end
    endtask

    task automatic test_capture();
        int lat;
        logic [7:0] out;
        lat = -1;
        out = 8'h00;
        bus.start  = 1'b1;
        bus.In_BCD = 8'h21;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.In_BCD = 8'h98;
            if (bus.done && lat < 0) begin
                lat = cyc;
                out = bus.Out_Bin;
            end
        end
        n_vec++;
        if (out !== 8'h15 || lat != 10) begin
            n_fail++;
            $display("FAIL capture_operand: out=%h cycle %0d, need 15 10", out, lat);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_max();
        test_back_to_back();
        test_invalid();
        test_ignored_start();
        test_reset_mid();
        test_capture();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time bound in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
